// File: rtl/non_hwt_pkg.sv
// non_hwt_pkg: shared types, vector-to-pin mapping and golden function for the non_hwt self-test
package non_hwt_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
  localparam int NUM_VEC = 16;
  localparam int POS_A = 3;
  localparam int POS_B = 2;
  localparam int POS_C = 1;
  localparam int POS_D = 0;
  function automatic logic golden_y(input logic [3:0] vec);
    return vec[POS_D] & ((vec[POS_A] & vec[POS_B]) | vec[POS_C]);
  endfunction
endpackage

// File: rtl/non_hwt_scan_ctrl_if.sv
// non_hwt_scan_ctrl_if: control/status and cell-pin bundle between tester, controller and cell
interface non_hwt_scan_ctrl_if;
  logic start, abort;
  logic dut_a, dut_b, dut_c, dut_d, dut_y;
  logic busy, done, pass, fail_valid;
  logic [4:0] err_cnt;
  logic [3:0] first_fail_vec;
  modport master (output start, abort, dut_y,
                  input dut_a, dut_b, dut_c, dut_d, busy, done, pass, fail_valid, err_cnt, first_fail_vec);
  modport slave (input start, abort, dut_y,
                 output dut_a, dut_b, dut_c, dut_d, busy, done, pass, fail_valid, err_cnt, first_fail_vec);
endinterface

// File: rtl/non_hwt_scan_ctrl.sv
// non_hwt_scan_ctrl: walks all 16 vectors through the non_hwt cell and tallies mismatches against golden Y
module non_hwt_scan_ctrl
  import non_hwt_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input logic clk,
  input logic rst,
  non_hwt_scan_ctrl_if.slave bus
);
  state_t state;
  logic [3:0] vec, cnt, pins;
  logic mism;
  assign mism = bus.dut_y != golden_y(vec);
  assign bus.dut_a = pins[POS_A];
  assign bus.dut_b = pins[POS_B];
  assign bus.dut_c = pins[POS_C];
  assign bus.dut_d = pins[POS_D];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec <= '0;
      cnt <= '0;
      pins <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
      bus.err_cnt <= '0;
      bus.fail_valid <= 1'b0;
      bus.first_fail_vec <= '0;
    end else if (bus.abort) begin
      // partial results stay visible for diagnosis
      state <= IDLE;
      pins <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state <= APPLY;
            vec <= '0;
            cnt <= '0;
            pins <= '0;
            bus.busy <= 1'b1;
            bus.pass <= 1'b0;
            bus.err_cnt <= '0;
            bus.fail_valid <= 1'b0;
            bus.first_fail_vec <= '0;
          end
        end
        APPLY: begin
          state <= cnt == 4'(SETTLE - 1) ? CHECK : APPLY;
          cnt <= cnt == 4'(SETTLE - 1) ? '0 : cnt + 4'd1;
        end
        CHECK: begin
          if (mism) begin
            bus.err_cnt <= bus.err_cnt + 5'd1;
            if (!bus.fail_valid) begin
              bus.fail_valid <= 1'b1;
              bus.first_fail_vec <= vec;
            end
          end
          if (vec == 4'(NUM_VEC - 1)) begin
            state <= DONE;
            pins <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= bus.err_cnt == '0 && !mism;
          end else begin
            state <= APPLY;
            vec <= vec + 4'd1;
            pins <= vec + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_non_hwt_scan_ctrl.sv
// tb_non_hwt_scan_ctrl: drives the scan controller against a fault-injectable non_hwt cell model
module tb_non_hwt_scan_ctrl;
  localparam int SETTLE = 2;
  localparam int PER = SETTLE + 1;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] flip = '0;
  int n_vec = 0, n_mis = 0;
  non_hwt_scan_ctrl_if bus ();
  non_hwt_scan_ctrl #(.SETTLE(SETTLE)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // cell under test: clean equation, with Y inverted on any vector whose flip bit is set
  logic [3:0] cell_vec;
  assign cell_vec = {bus.dut_a, bus.dut_b, bus.dut_c, bus.dut_d};
  assign bus.dut_y = ((bus.dut_a & bus.dut_b) | bus.dut_c) & bus.dut_d ^ flip[cell_vec];
  typedef struct {
    logic [15:0] mask;
    logic [4:0] err;
    logic fv;
    logic [3:0] ffv;
    logic pass;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic vec_t model(input logic [15:0] m);
    vec_t r;
    r.mask = m;
    r.err = '0;
    r.fv = 1'b0;
    r.ffv = '0;
    for (int k = 0; k < 16; k++)
      if (m[k]) begin
        if (!r.fv) r.ffv = 4'(k);
        r.fv = 1'b1;
        r.err++;
      end
    r.pass = r.err == 0;
    return r;
  endfunction
  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_pass"}, bus.pass, 0);
    chk({tag, "_err"}, bus.err_cnt, 0);
    chk({tag, "_fv"}, bus.fail_valid, 0);
    chk({tag, "_ffv"}, bus.first_fail_vec, 0);
    chk({tag, "_pins"}, cell_vec, 0);
  endtask
  task automatic run_scan(input vec_t e, input int extra);
    int edges = 0, bad = 0;
    flip = e.mask;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (!bus.done && edges < 200) begin
      if (edges < 16 * PER && (cell_vec != 4'(edges / PER) || !bus.busy)) bad++;
      if (edges == extra) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      edges++;
    end
    chk("done_latency", edges, 16 * PER);
    chk("pin_sequence", bad, 0);
    chk("busy_at_done", bus.busy, 0);
    chk("err_cnt", bus.err_cnt, e.err);
    chk("fail_valid", bus.fail_valid, e.fv);
    chk("first_fail_vec", bus.first_fail_vec, e.ffv);
    chk("pass", bus.pass, e.pass);
    @(posedge clk); #1;
    chk("done_one_cycle", bus.done, 0);
  endtask
  vec_t tbl[5];
  initial begin
    int waited, pulses;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tbl[0] = '{16'h0000, 5'd0, 1'b0, 4'd0, 1'b1};
    tbl[1] = '{16'h2000, 5'd1, 1'b1, 4'd13, 1'b0};
    tbl[2] = '{16'hA888, 5'd5, 1'b1, 4'd3, 1'b0};
    tbl[3] = '{16'hFFFF, 5'd16, 1'b1, 4'd0, 1'b0};
    tbl[4] = '{16'h8000, 5'd1, 1'b1, 4'd15, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) run_scan(tbl[i], -1);
    for (int i = 0; i < 6; i++) run_scan(model(16'($urandom)), -1);
    // abort while vector 7 is applied; vectors 0..6 already checked under stuck-at-0
    flip = 16'hA888;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    waited = 0;
    while (cell_vec != 4'd7 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("reach_vec7", cell_vec, 7);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_pins", cell_vec, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_pass", bus.pass, 0);
    chk("abort_err_kept", bus.err_cnt, 1);
    chk("abort_fv_kept", bus.fail_valid, 1);
    chk("abort_ffv_kept", bus.first_fail_vec, 3);
    pulses = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    run_scan(tbl[0], -1);
    // second start while busy must not disturb timing
    run_scan(tbl[1], 10);
    // start and abort together in IDLE: nothing starts, results untouched
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("sa_busy", bus.busy, 0);
    chk("sa_err_kept", bus.err_cnt, 1);
    @(posedge clk); #1;
    chk("sa_idle", bus.busy, 0);
    // reset in the middle of a scan
    flip = 16'hFFFF;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero("midrst");
    @(posedge clk); #1;
    chk("midrst_idle", bus.busy, 0);
    run_scan(tbl[0], -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/non_hwt_scan_ctrl.md
# non_hwt_scan_ctrl

Self-test sequencer for the `non_hwt` reference logic cell. It applies all 16 input vectors to the cell's A/B/C/D pins and samples Y after a programmable settle time. Each sample is compared against the golden function Y = D & ((A & B) | C). The controller reports a mismatch count and the first failing vector, which lets a trojan-free netlist be distinguished from a tampered one. It sits between the test/control interface and the cell under test.

## Interface
- `SETTLE`, default 2: cycles vector is held before sampling; legal range 1..15.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin scan; sampled only in IDLE.
- `abort`  in  1  terminate scan; sampled in every state.
- `dut_a`, `dut_b`, `dut_c`, `dut_d`  out  1 each  registered drive to cell inputs A..D.
- `dut_y`  in  1  cell output Y.
- `busy`  out  1  high in APPLY/CHECK.
- `done`  out  1  one-cycle pulse on scan completion.
- `pass`  out  1  high after completed scan with zero mismatches.
- `err_cnt`  out  5  mismatch count, 0..16.
- `fail_valid`  out  1  at least one mismatch recorded.
- `first_fail_vec`  out  4  vector index of first mismatch.

## Operation
- Vector index `vec[3:0]` maps {A,B,C,D} = {vec[3],vec[2],vec[1],vec[0]}; scan order 0→15.
- Golden ones: vectors 3, 7, 11, 13, 15; all others expect 0.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE + `start` & !`abort` → APPLY, vec=0, settle cnt=0. Results clear on the same edge: err_cnt=0, fail_valid=0, pass=0, first_fail_vec=0.
- APPLY: hold dut_* = vec for SETTLE cycles, then → CHECK.
- CHECK: compare `dut_y` against golden(vec). On mismatch, err_cnt+1. If fail_valid=0, latch first_fail_vec=vec and set fail_valid.
- CHECK leaving with vec<15 → APPLY with vec+1.
- CHECK leaving with vec=15 → DONE.
- DONE: done=1 and pass=(final err_cnt==0) for one cycle, then → IDLE.
- Results hold until the next accepted start.
- `abort` in any state → IDLE on the next edge.
  - dut_* forced to 0; busy=0; no done pulse; pass=0.
  - err_cnt/fail_valid/first_fail_vec retain partial values.
- `abort` wins over a simultaneous `start`.
- `start` outside IDLE is ignored.
- `rst` forces IDLE; all outputs 0, including dut_*, busy, done, pass, err_cnt, fail_valid, first_fail_vec.
- err_cnt cannot overflow: 5 bits cover 16.

## Timing
- All outputs are registered; `dut_y` is sampled at the clock edge that ends a CHECK cycle.
- Per vector: SETTLE+1 cycles (SETTLE APPLY cycles + 1 CHECK cycle).
- Let E0 be the edge that accepts start. Vector k is driven from edge E0+k·(SETTLE+1).
- done is high in the cycle after edge E0+16·(SETTLE+1). For SETTLE=2, this is 48 edges after E0.
- busy rises at E0 and falls at the edge entering DONE.
- Earliest restart: start sampled on the first IDLE cycle after DONE.

## Structure
- Package `non_hwt_pkg`:
  - state enum;
  - `NUM_VEC`=16;
  - vector-to-pin bit positions;
  - function `golden_y(vec)`.
- Single module, no sub-modules; settle counter and vector counter are inline.
- Bench instantiates `non_hwt` as the DUT, with a wrapper that can inject faults on Y.

## Test plan
- Clean `non_hwt`, SETTLE=2: start → done 48 edges after E0; err_cnt=0, pass=1, fail_valid=0.
- Trojan model with Y inverted only at vec=13 → err_cnt=1, first_fail_vec=13, pass=0.
- Y stuck-at-0 → err_cnt=5, first_fail_vec=3, fail_valid=1, pass=0.
- abort while vec=7 → next edge: busy=0, dut_*=0, no done. A following start runs a full clean scan with pass=1.
- start pulsed during busy is ignored (done timing unchanged). start+abort in the same IDLE cycle → stays IDLE, busy=0.
- rst mid-scan → next edge: every output 0, state IDLE. A subsequent start then behaves as in scenario 1.
